// File: rtl/skid_pipeline_pkg.sv
// Shared types and default sizing for the cascaded skid-buffer pipeline.
package skid_pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/skid_pipeline_skid_stage.sv
// One two-entry skid stage: main entry drives the output, skid entry absorbs
// the beat that arrives while the downstream is stalled.
module skid_stage
    import skid_pipeline_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output stage_state_e state
);

    stage_state_e state_q, state_n;
    logic [W-1:0] main_q, main_n;
    logic [W-1:0] skid_q, skid_n;
    logic         push, pop;

    // Ready depends only on the registered state, so out_ready never reaches in_ready.
    assign push = in_valid && (state_q != FULL);
    assign pop  = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_n = BUSY;
                        main_n  = in_data;
                    end
                end
                BUSY: begin
                    case ({push, pop})
                        2'b11: main_n = in_data;
                        2'b10: begin
                            state_n = FULL;
                            skid_n  = in_data;
                        end
                        2'b01: state_n = EMPTY;
                        default: state_n = BUSY;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        state_n = BUSY;
                        main_n  = skid_q;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign state     = state_q;

endmodule

// File: rtl/skid_pipeline.sv
// DEPTH cascaded skid stages with a held-beat occupancy counter and
// synchronous flush.
module skid_pipeline
    import skid_pipeline_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [W-1:0]                   out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

    localparam int OW = $clog2(2*DEPTH+1);

    // Handshake: a beat moves across any link exactly when valid and ready are
    // both 1 at a rising edge; valid never waits on ready, and once raised a
    // valid beat stays put until it is taken (or discarded by flush/reset).
    logic         link_valid [DEPTH+1];
    logic         link_ready [DEPTH+1];
    logic [W-1:0] link_data  [DEPTH+1];
    stage_state_e stage_state [DEPTH];

    assign link_valid[0]     = in_valid;
    assign link_data[0]      = in_data;
    assign link_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        skid_stage #(.W(W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (link_valid[i]),
            .in_data   (link_data[i]),
            .out_valid (link_valid[i+1]),
            .out_ready (link_ready[i+1]),
            .out_data  (link_data[i+1]),
            .state     (stage_state[i])
        );
        assign link_ready[i] = (stage_state[i] != FULL);
    end

    assign in_ready  = rst_n && !flush && link_ready[0];
    assign out_valid = link_valid[DEPTH];
    assign out_data  = link_data[DEPTH];

    logic          in_xfer, out_xfer;
    logic [OW-1:0] occ_q;

    // A beat shown during a flush cycle is discarded, not delivered.
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OW'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_q <= occ_q - OW'(1);
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_skid_pipeline.sv
// Bench for skid_pipeline (W=8, DEPTH=2): vector table, directed corner
// sequences and random traffic against a per-stage FIFO reference model.
module tb_skid_pipeline;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(2*DEPTH+1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [OW-1:0] occupancy;

    skid_pipeline #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vector record ----------------
    typedef struct {
        logic          rst_n;
        logic          flush;
        logic          in_valid;
        logic [W-1:0]  in_data;
        logic          out_ready;
        logic          use_tbl;
        logic          chk_all;
        logic          e_ir;
        logic          e_ov;
        logic [W-1:0]  e_od;
        logic [OW-1:0] e_occ;
    } vec_t;

    function automatic vec_t tv(logic r, logic fl, logic iv, logic [W-1:0] d, logic o,
                                logic ca, logic eir, logic eov, logic [W-1:0] eod,
                                logic [OW-1:0] eocc);
        vec_t v;
        v.rst_n = r; v.flush = fl; v.in_valid = iv; v.in_data = d; v.out_ready = o;
        v.use_tbl = 1'b1; v.chk_all = ca;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_occ = eocc;
        return v;
    endfunction

    function automatic vec_t mk(logic r, logic fl, logic iv, logic [W-1:0] d, logic o);
        vec_t v;
        v = tv(r, fl, iv, d, o, 1'b0, 1'b0, 1'b0, '0, '0);
        v.use_tbl = 1'b0;
        return v;
    endfunction

    // ---------------- counters and checker ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: each stage is a 2-entry FIFO ----------------
    logic [W-1:0] m_buf  [DEPTH][2];
    int           m_cnt  [DEPTH];
    logic [W-1:0] m_last [DEPTH];
    logic         model_ok = 1'b0;

    task automatic model_edge(input vec_t v);
        logic [W-1:0] b [DEPTH][2];
        int           c [DEPTH];
        logic         pop, push;
        logic [W-1:0] nd;
        b = m_buf;
        c = m_cnt;
        if (!v.rst_n || v.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_cnt[i] = 0;
                if (!v.rst_n) m_last[i] = '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == DEPTH-1) pop = (c[i] > 0) && v.out_ready;
                else              pop = (c[i] > 0) && (c[i+1] < 2);
                if (i == 0) begin
                    push = v.in_valid && (c[0] < 2);
                    nd   = v.in_data;
                end else begin
                    push = (c[i-1] > 0) && (c[i] < 2);
                    nd   = b[i-1][0];
                end
                if (pop) begin
                    m_buf[i][0] = m_buf[i][1];
                    m_cnt[i]--;
                end
                if (push) begin
                    m_buf[i][m_cnt[i]] = nd;
                    m_cnt[i]++;
                end
                if (m_cnt[i] > 0) m_last[i] = m_buf[i][0];
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    logic          last_ir, last_ov;
    logic [W-1:0]  last_od;
    logic [OW-1:0] last_occ;

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input vec_t v);
        int occ_sum;
        rst_n = v.rst_n; flush = v.flush; in_valid = v.in_valid;
        in_data = v.in_data; out_ready = v.out_ready;
        @(negedge clk);
        last_ir = in_ready; last_ov = out_valid; last_od = out_data; last_occ = occupancy;
        if (v.use_tbl) begin
            check("tbl_in_ready", 32'(in_ready), 32'(v.e_ir));
            if (v.chk_all) begin
                check("tbl_out_valid", 32'(out_valid), 32'(v.e_ov));
                check("tbl_out_data",  32'(out_data),  32'(v.e_od));
                check("tbl_occupancy", 32'(occupancy), 32'(v.e_occ));
            end
        end
        if (model_ok) begin
            occ_sum = 0;
            for (int i = 0; i < DEPTH; i++) occ_sum += m_cnt[i];
            check("model_in_ready",  32'(in_ready),
                  32'(v.rst_n && !v.flush && (m_cnt[0] < 2)));
            check("model_out_valid", 32'(out_valid), 32'(m_cnt[DEPTH-1] > 0));
            check("model_out_data",  32'(out_data),  32'(m_last[DEPTH-1]));
            check("model_occupancy", 32'(occupancy), 32'(occ_sum));
            if (v.rst_n && !v.flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                else                   check("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (v.rst_n && !v.flush && in_valid && in_ready) exp_q.push_back(in_data);
        end
        if (!v.rst_n || v.flush) exp_q.delete();
        @(posedge clk);
        model_edge(v);
        if (!v.rst_n) model_ok = 1'b1;
        #1;
    endtask

    // ---------------- test ----------------
    vec_t tbl [18];
    int   occ_ref;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset, single beat, back-pressure and release
        tbl[0]  = tv(0,0,1,8'hAA,0, 0, 0,0,8'h00,0);
        tbl[1]  = tv(0,0,1,8'hAA,0, 1, 0,0,8'h00,0);
        tbl[2]  = tv(1,0,0,8'h00,1, 1, 1,0,8'h00,0);
        tbl[3]  = tv(1,0,1,8'h01,1, 1, 1,0,8'h00,0);
        tbl[4]  = tv(1,0,0,8'h00,1, 1, 1,0,8'h00,1);
        tbl[5]  = tv(1,0,0,8'h00,1, 1, 1,1,8'h01,1);
        tbl[6]  = tv(1,0,0,8'h00,0, 1, 1,0,8'h01,0);
        tbl[7]  = tv(1,0,1,8'h02,0, 1, 1,0,8'h01,0);
        tbl[8]  = tv(1,0,1,8'h03,0, 1, 1,0,8'h01,1);
        tbl[9]  = tv(1,0,1,8'h04,0, 1, 1,1,8'h02,2);
        tbl[10] = tv(1,0,1,8'h05,0, 1, 1,1,8'h02,3);
        tbl[11] = tv(1,0,1,8'h06,0, 1, 0,1,8'h02,4);
        tbl[12] = tv(1,0,1,8'h06,1, 1, 0,1,8'h02,4);
        tbl[13] = tv(1,0,1,8'h06,1, 1, 0,1,8'h03,3);
        tbl[14] = tv(1,0,1,8'h06,1, 1, 1,1,8'h04,2);
        tbl[15] = tv(1,0,0,8'h00,1, 1, 1,1,8'h05,2);
        tbl[16] = tv(1,0,0,8'h00,1, 1, 1,1,8'h06,1);
        tbl[17] = tv(1,0,0,8'h00,1, 1, 1,0,8'h06,0);

        @(posedge clk); #1;
        for (int k = 0; k < 18; k++) step(tbl[k]);

        // streaming: in_ready never drops, outputs on consecutive cycles
        occ_ref = -1;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) step(mk(1,0,1,W'(8'h06 + c),1));
            else       step(mk(1,0,0,8'h00,1));
            check("stream_in_ready", 32'(last_ir), 32'd1);
            if (c >= 2 && c <= 6) begin
                check("stream_out_valid", 32'(last_ov), 32'd1);
                check("stream_out_data",  32'(last_od), 32'(8'h06 + c - 2));
            end
            if (c == 2) occ_ref = int'(last_occ);
            if (c == 3 || c == 4) check("stream_occ_const", 32'(last_occ), 32'(occ_ref));
        end
        check("stream_idle_after", 32'(last_ov), 32'd0);

        // flush with three beats held and a beat offered
        step(mk(1,0,1,8'h10,0));
        step(mk(1,0,1,8'h11,0));
        step(mk(1,0,1,8'h12,0));
        step(mk(1,1,1,8'h0B,0));
        check("flush_in_ready", 32'(last_ir), 32'd0);
        check("flush_occ_before", 32'(last_occ), 32'd3);
        for (int c = 0; c < 4; c++) begin
            step(mk(1,0,0,8'h00,1));
            check("flush_out_valid", 32'(last_ov), 32'd0);
            check("flush_occupancy", 32'(last_occ), 32'd0);
        end

        // flush while a beat is offered with out_ready=1: it is discarded
        step(mk(1,0,1,8'h30,0));
        step(mk(1,0,0,8'h00,0));
        step(mk(1,1,0,8'h00,1));
        step(mk(1,0,0,8'h00,1));
        check("flush_discard_ov", 32'(last_ov), 32'd0);

        // mid-stream reset
        step(mk(1,0,1,8'h20,1));
        step(mk(1,0,1,8'h21,1));
        step(mk(1,0,1,8'h22,1));
        step(mk(0,0,1,8'h23,1));
        check("rst_in_ready_low", 32'(last_ir), 32'd0);
        step(mk(1,0,1,8'h24,1));
        check("rst_occ_zero", 32'(last_occ), 32'd0);
        check("rst_out_valid", 32'(last_ov), 32'd0);
        check("rst_in_ready_back", 32'(last_ir), 32'd1);
        step(mk(1,0,1,8'h25,1));
        step(mk(1,0,1,8'h26,1));
        for (int c = 0; c < 5; c++) step(mk(1,0,0,8'h00,1));
        check("rst_drained", 32'(exp_q.size()), 32'd0);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            step(mk(logic'($urandom_range(0,49) != 0),
                    logic'($urandom_range(0,24) == 0),
                    logic'($urandom_range(0,2) != 0),
                    W'($urandom_range(0,255)),
                    logic'($urandom_range(0,3) != 0)));
        end
        for (int c = 0; c < 10; c++) step(mk(1,0,0,8'h00,1));
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_occupancy", 32'(last_occ), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
